fft_bitrev_reorder: RTL and testbench

- Output reorder buffer placed directly after the final R2²SDF stage. It consumes that stage's o_data/o_valid stream.
- The SDF pipeline emits each N-point frame in bit-reversed index order. This block writes each sample to the bit-reversed address of a ping-pong RAM.
- It reads frames back in natural order, 0..N-1, over a valid/ready output handshake.
- Two banks let one frame be written while the previous frame drains.

---
 rtl/fft_bitrev_reorder.sv | 195 +++++++++++++++++++
 tb/tb_fft_bitrev_reorder.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: bit-reversed SDF frames in, natural-order frames out over valid/ready.
// Optional define FFT_REORDER_FRAME_MARK_EN adds o_sof/o_eof frame markers.
module fft_bitrev_reorder #(
  parameter int DWIDTH = 32,
  parameter int N_LOG  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DWIDTH-1:0] i_data,
  input  logic              i_valid,
  output logic [DWIDTH-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_overflow
`ifdef FFT_REORDER_FRAME_MARK_EN
  ,
  output logic              o_sof,
  output logic              o_eof
`endif
);

  localparam int DEPTH = 1 << N_LOG;
  localparam logic [N_LOG-1:0] LAST_ADDR = '1;

  typedef enum logic [0:0] {RD_IDLE, RD_STREAM} rd_state_t;

  logic [N_LOG-1:0]  wr_cnt_reg;
  logic [N_LOG-1:0]  wr_addr;
  logic              wr_bank_reg;
  logic              wr_en;
  logic              wr_wrap;
  logic [1:0]        full_reg;
  logic [1:0]        full_next;
  logic              overflow_reg;

  rd_state_t         rd_state_reg;
  rd_state_t         rd_state_next;
  logic [N_LOG-1:0]  rd_addr_reg;
  logic [N_LOG-1:0]  rd_addr_next;
  logic              rd_bank_reg;
  logic              rd_bank_next;
  logic              rd_issue;
  logic              rd_free;
  logic              rd_vld_reg;
  logic              rd_src_reg;
  logic [DWIDTH-1:0] rd_q;

  logic [DWIDTH-1:0] data_reg;
  logic              valid_reg;
  logic [DWIDTH-1:0] skid_reg;
  logic              skid_valid_reg;
  logic              pop;
  logic              room;
  logic              head_from_skid;
  logic              head_from_rd;
  logic              skid_load;

  for (genvar gi = 0; gi < N_LOG; gi++) begin : g_bitrev
    assign wr_addr[gi] = wr_cnt_reg[N_LOG-1-gi];
  end

  assign wr_en   = i_valid && !full_reg[wr_bank_reg];
  assign wr_wrap = wr_en && (wr_cnt_reg == LAST_ADDR);

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    logic [DWIDTH-1:0] mem [DEPTH];
    logic [DWIDTH-1:0] rd_word;
    always_ff @(posedge clk) begin
      if (wr_en && (wr_bank_reg == 1'(gi))) mem[wr_addr] <= i_data;
      if (rd_issue && (rd_bank_reg == 1'(gi))) rd_word <= mem[rd_addr_reg];
    end
  end

  assign rd_q = rd_src_reg ? g_bank[1].rd_word : g_bank[0].rd_word;

  // Output holds up to two words (head + skid); a read is issued only if its
  // word is guaranteed a slot even when the head stalls next cycle.
  assign pop  = valid_reg && i_ready;
  assign room = ({1'b0, valid_reg} + {1'b0, skid_valid_reg} + {1'b0, rd_vld_reg})
                <= ({1'b0, pop} + 2'd1);

  assign head_from_skid = pop && skid_valid_reg;
  assign head_from_rd   = rd_vld_reg && (!valid_reg || (pop && !skid_valid_reg));
  assign skid_load      = rd_vld_reg && ((pop && skid_valid_reg) || (!pop && valid_reg));

  always_comb begin
    rd_state_next = rd_state_reg;
    rd_addr_next  = rd_addr_reg;
    rd_bank_next  = rd_bank_reg;
    rd_issue      = 1'b0;
    rd_free       = 1'b0;
    case (rd_state_reg)
      RD_IDLE: begin
        if (full_reg[rd_bank_reg] && room) begin
          rd_issue      = 1'b1;
          rd_addr_next  = rd_addr_reg + 1'b1;
          rd_state_next = RD_STREAM;
        end
      end
      RD_STREAM: begin
        if (room) begin
          rd_issue     = 1'b1;
          rd_addr_next = rd_addr_reg + 1'b1;
          // Bank is released once its last word has left the RAM, which lets
          // the writer reuse it without stalling a continuous input stream.
          if (rd_addr_reg == LAST_ADDR) begin
            rd_free       = 1'b1;
            rd_bank_next  = ~rd_bank_reg;
            rd_state_next = RD_IDLE;
          end
        end
      end
      default: rd_state_next = RD_IDLE;
    endcase
  end

  always_comb begin
    full_next = full_reg;
    if (wr_wrap) full_next[wr_bank_reg] = 1'b1;
    if (rd_free) full_next[rd_bank_reg] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_cnt_reg     <= '0;
      wr_bank_reg    <= 1'b0;
      full_reg       <= 2'b00;
      overflow_reg   <= 1'b0;
      rd_state_reg   <= RD_IDLE;
      rd_addr_reg    <= '0;
      rd_bank_reg    <= 1'b0;
      rd_vld_reg     <= 1'b0;
      rd_src_reg     <= 1'b0;
      data_reg       <= '0;
      valid_reg      <= 1'b0;
      skid_reg       <= '0;
      skid_valid_reg <= 1'b0;
    end else begin
      if (wr_en) wr_cnt_reg <= wr_cnt_reg + 1'b1;
      if (wr_wrap) wr_bank_reg <= ~wr_bank_reg;
      if (i_valid && full_reg[wr_bank_reg]) overflow_reg <= 1'b1;
      full_reg     <= full_next;
      rd_state_reg <= rd_state_next;
      rd_addr_reg  <= rd_addr_next;
      rd_bank_reg  <= rd_bank_next;
      rd_vld_reg   <= rd_issue;
      if (rd_issue) rd_src_reg <= rd_bank_reg;
      if (head_from_skid) data_reg <= skid_reg;
      else if (head_from_rd) data_reg <= rd_q;
      valid_reg <= head_from_skid || head_from_rd || (valid_reg && !pop);
      if (skid_load) skid_reg <= rd_q;
      skid_valid_reg <= skid_load || (skid_valid_reg && !pop);
    end
  end

  assign o_data     = data_reg;
  assign o_valid    = valid_reg;
  assign o_overflow = overflow_reg;

`ifdef FFT_REORDER_FRAME_MARK_EN
  // Frame markers ride alongside each word through the same read/skid path.
  logic rd_sof_reg, rd_eof_reg, skid_sof_reg, skid_eof_reg, sof_reg, eof_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_sof_reg   <= 1'b0;
      rd_eof_reg   <= 1'b0;
      skid_sof_reg <= 1'b0;
      skid_eof_reg <= 1'b0;
      sof_reg      <= 1'b0;
      eof_reg      <= 1'b0;
    end else begin
      if (rd_issue) begin
        rd_sof_reg <= (rd_addr_reg == '0);
        rd_eof_reg <= (rd_addr_reg == LAST_ADDR);
      end
      if (head_from_skid) begin
        sof_reg <= skid_sof_reg;
        eof_reg <= skid_eof_reg;
      end else if (head_from_rd) begin
        sof_reg <= rd_sof_reg;
        eof_reg <= rd_eof_reg;
      end
      if (skid_load) begin
        skid_sof_reg <= rd_sof_reg;
        skid_eof_reg <= rd_eof_reg;
      end
    end
  end

  assign o_sof = valid_reg && sof_reg;
  assign o_eof = valid_reg && eof_reg;
`endif

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Self-checking bench for fft_bitrev_reorder (N_LOG=3) against a natural-order frame model.
module tb_fft_bitrev_reorder;
  localparam int DW = 32;
  localparam int NL = 3;
  localparam int N  = 1 << NL;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          i_valid = 1'b0;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          i_ready = 1'b0;
  logic          o_overflow;
`ifdef FFT_REORDER_FRAME_MARK_EN
  logic          o_sof;
  logic          o_eof;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_in_cyc = 0;

  int got_data[$];
  int got_cyc[$];
  bit got_sof[$];
  bit got_eof[$];
  int first_valid_cyc;
  int stall_bad;
  bit timed_out;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft_bitrev_reorder #(.DWIDTH(DW), .N_LOG(NL)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_overflow (o_overflow)
`ifdef FFT_REORDER_FRAME_MARK_EN
    ,
    .o_sof      (o_sof),
    .o_eof      (o_eof)
`endif
  );

  function automatic int bitrev(input int k);
    int r = 0;
    for (int b = 0; b < NL; b++)
      if (((k >> b) & 1) == 1) r += 1 << (NL - 1 - b);
    return r;
  endfunction

  task automatic apply_reset();
    i_valid = 1'b0;
    i_ready = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Streams one frame given in natural order, so sample k carries nat[bitrev(k)].
  task automatic feed_frame(input int nat[N], input bit gaps);
    for (int k = 0; k < N; k++) begin
      while (gaps && $urandom_range(0, 3) != 0) begin
        i_valid = 1'b0;
        i_data  = $urandom;
        @(posedge clk);
        #1;
      end
      i_valid = 1'b1;
      i_data  = nat[bitrev(k)];
      @(posedge clk);
      #1;
    end
    last_in_cyc = cyc;
  endtask

  // Records accepted beats; ready_mode 1 randomises i_ready at 50%.
  task automatic collect(input int n, input int budget, input int ready_mode);
    bit stalled = 1'b0;
    logic [DW-1:0] held = '0;
    got_data.delete();
    got_cyc.delete();
    got_sof.delete();
    got_eof.delete();
    first_valid_cyc = -1;
    stall_bad = 0;
    timed_out = 1'b0;
    for (int c = 0; c < budget && got_data.size() < n; c++) begin
      @(negedge clk);
      if (stalled && (!o_valid || o_data !== held)) stall_bad++;
      if (o_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (o_valid && i_ready) begin
        got_data.push_back(int'(o_data));
        got_cyc.push_back(cyc);
`ifdef FFT_REORDER_FRAME_MARK_EN
        got_sof.push_back(o_sof);
        got_eof.push_back(o_eof);
`endif
      end
      stalled = o_valid && !i_ready;
      held = o_data;
      @(posedge clk);
      #1;
      if (ready_mode == 1) i_ready = ($urandom_range(0, 1) == 1);
    end
    if (got_data.size() < n) timed_out = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_o_valid got=%0b exp=0", o_valid); end
    checks++; if (o_data !== '0) begin failures++; $display("FAIL reset_o_data got=%0h exp=0", o_data); end
    checks++; if (o_overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0b exp=0", o_overflow); end
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_idle_valid got=%0b exp=0", o_valid); end
  endtask

  task automatic test_basic();
    int nat[N];
    apply_reset();
    i_ready = 1'b1;
    for (int i = 0; i < N; i++) nat[i] = i;
    fork
      begin feed_frame(nat, 1'b0); i_valid = 1'b0; end
      collect(N, 60, 0);
    join
    checks++; if (timed_out) begin failures++; $display("FAIL basic_count got=%0d exp=%0d", got_data.size(), N); end
    for (int i = 0; i < got_data.size(); i++) begin
      checks++; if (got_data[i] != i) begin failures++; $display("FAIL basic_data[%0d] got=%0d exp=%0d", i, got_data[i], i); end
      checks++; if (got_cyc[i] != got_cyc[0] + i) begin failures++; $display("FAIL basic_gap[%0d] got=%0d exp=%0d", i, got_cyc[i], got_cyc[0] + i); end
    end
    checks++; if (first_valid_cyc != last_in_cyc + 2) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", first_valid_cyc, last_in_cyc + 2); end
    checks++; if (o_overflow !== 1'b0) begin failures++; $display("FAIL basic_overflow got=%0b exp=0", o_overflow); end
  endtask

  task automatic test_back_to_back();
    int nat[N];
    apply_reset();
    i_ready = 1'b1;
    fork
      begin
        for (int f = 0; f < 4; f++) begin
          for (int i = 0; i < N; i++) nat[i] = 8 * f + i;
          feed_frame(nat, 1'b0);
        end
        i_valid = 1'b0;
      end
      collect(4 * N, 200, 0);
    join
    checks++; if (timed_out) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", got_data.size(), 4 * N); end
    for (int i = 0; i < got_data.size(); i++) begin
      checks++; if (got_data[i] != i) begin failures++; $display("FAIL b2b_data[%0d] got=%0d exp=%0d", i, got_data[i], i); end
      checks++; if (got_cyc[i] != got_cyc[0] + i) begin failures++; $display("FAIL b2b_gap[%0d] got=%0d exp=%0d", i, got_cyc[i], got_cyc[0] + i); end
`ifdef FFT_REORDER_FRAME_MARK_EN
      checks++; if (got_sof[i] != (i % N == 0)) begin failures++; $display("FAIL b2b_sof[%0d] got=%0b exp=%0b", i, got_sof[i], (i % N == 0)); end
      checks++; if (got_eof[i] != (i % N == N - 1)) begin failures++; $display("FAIL b2b_eof[%0d] got=%0b exp=%0b", i, got_eof[i], (i % N == N - 1)); end
`endif
    end
    checks++; if (o_overflow !== 1'b0) begin failures++; $display("FAIL b2b_overflow got=%0b exp=0", o_overflow); end
  endtask

  task automatic test_backpressure();
    int nat[N];
    int extra = 0;
    apply_reset();
    for (int i = 0; i < N; i++) nat[i] = i;
    fork
      begin feed_frame(nat, 1'b0); i_valid = 1'b0; end
      collect(N, 300, 1);
    join
    i_ready = 1'b1;
    checks++; if (timed_out) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", got_data.size(), N); end
    for (int i = 0; i < got_data.size(); i++) begin
      checks++; if (got_data[i] != i) begin failures++; $display("FAIL bp_data[%0d] got=%0d exp=%0d", i, got_data[i], i); end
    end
    checks++; if (stall_bad != 0) begin failures++; $display("FAIL bp_stall_stable got=%0d exp=0", stall_bad); end
    repeat (10) begin
      @(negedge clk);
      if (o_valid) extra++;
    end
    checks++; if (extra != 0) begin failures++; $display("FAIL bp_extra_beats got=%0d exp=0", extra); end
  endtask

  task automatic test_random();
    int nat[N];
    int exp_q[$];
    apply_reset();
    fork
      begin
        for (int f = 0; f < 3; f++) begin
          for (int w = 0; w < 2000 && f >= 2 && got_data.size() < (f - 1) * N; w++) begin
            i_valid = 1'b0;
            @(posedge clk);
            #1;
          end
          for (int i = 0; i < N; i++) begin
            nat[i] = int'($urandom);
            exp_q.push_back(nat[i]);
          end
          feed_frame(nat, 1'b1);
        end
        i_valid = 1'b0;
      end
      collect(3 * N, 2000, 1);
    join
    i_ready = 1'b1;
    checks++; if (timed_out) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", got_data.size(), 3 * N); end
    for (int i = 0; i < got_data.size() && i < exp_q.size(); i++) begin
      checks++; if (got_data[i] != exp_q[i]) begin failures++; $display("FAIL rand_data[%0d] got=%0h exp=%0h", i, got_data[i], exp_q[i]); end
    end
    checks++; if (stall_bad != 0) begin failures++; $display("FAIL rand_stall_stable got=%0d exp=0", stall_bad); end
    checks++; if (o_overflow !== 1'b0) begin failures++; $display("FAIL rand_overflow got=%0b exp=0", o_overflow); end
  endtask

  task automatic test_overflow();
    int nat[N];
    int extra = 0;
    apply_reset();
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < N; i++) nat[i] = 8 * f + i;
      feed_frame(nat, 1'b0);
    end
    checks++; if (o_overflow !== 1'b0) begin failures++; $display("FAIL ovf_before got=%0b exp=0", o_overflow); end
    for (int k = 0; k < N; k++) begin
      i_valid = 1'b1;
      i_data  = 16 + bitrev(k);
      @(posedge clk);
      #1;
      if (k == 0) begin
        checks++; if (o_overflow !== 1'b1) begin failures++; $display("FAIL ovf_rise got=%0b exp=1", o_overflow); end
      end
    end
    i_valid = 1'b0;
    checks++; if (o_valid !== 1'b1 || o_data !== 0) begin failures++; $display("FAIL ovf_hold got=%0b/%0d exp=1/0", o_valid, o_data); end
    i_ready = 1'b1;
    collect(2 * N, 100, 0);
    checks++; if (timed_out) begin failures++; $display("FAIL ovf_count got=%0d exp=%0d", got_data.size(), 2 * N); end
    for (int i = 0; i < got_data.size(); i++) begin
      checks++; if (got_data[i] != i) begin failures++; $display("FAIL ovf_data[%0d] got=%0d exp=%0d", i, got_data[i], i); end
    end
    repeat (12) begin
      @(negedge clk);
      if (o_valid) extra++;
    end
    checks++; if (extra != 0) begin failures++; $display("FAIL ovf_frame3_absent got=%0d exp=0", extra); end
    checks++; if (o_overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%0b exp=1", o_overflow); end
  endtask

  task automatic test_reset_midop();
    int nat[N];
    int extra = 0;
    apply_reset();
    i_ready = 1'b1;
    for (int i = 0; i < N; i++) nat[i] = i;
    feed_frame(nat, 1'b0);
    for (int k = 0; k < 5; k++) begin
      i_valid = 1'b1;
      i_data  = 8 + bitrev(k);
      @(posedge clk);
      #1;
    end
    checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL midop_draining got=%0b exp=1", o_valid); end
    #2;
    reset = 1'b0;
    i_valid = 1'b0;
    #1;
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL midop_async_valid got=%0b exp=0", o_valid); end
    checks++; if (o_data !== '0) begin failures++; $display("FAIL midop_async_data got=%0h exp=0", o_data); end
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) nat[i] = 100 + i;
    fork
      begin feed_frame(nat, 1'b0); i_valid = 1'b0; end
      collect(N, 60, 0);
    join
    checks++; if (timed_out) begin failures++; $display("FAIL midop_count got=%0d exp=%0d", got_data.size(), N); end
    for (int i = 0; i < got_data.size(); i++) begin
      checks++; if (got_data[i] != 100 + i) begin failures++; $display("FAIL midop_data[%0d] got=%0d exp=%0d", i, got_data[i], 100 + i); end
    end
    checks++; if (first_valid_cyc != last_in_cyc + 2) begin failures++; $display("FAIL midop_latency got=%0d exp=%0d", first_valid_cyc, last_in_cyc + 2); end
    repeat (12) begin
      @(negedge clk);
      if (o_valid) extra++;
    end
    checks++; if (extra != 0) begin failures++; $display("FAIL midop_residue got=%0d exp=0", extra); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_overflow();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
